// File: rtl/pwm_multi_ctrl_pkg.sv
// Shared constants and the divisor helper for the multi-channel PWM block.
// Optional build macro used by the channel: PWM_STAGGER_EN.
package pwm_multi_ctrl_pkg;

    localparam int STEPS_DEFAULT = 100;
    localparam int DUTY_MAX      = 100;
    localparam int POW_W         = 2;
    localparam int DIV_MAX       = 1000;
    localparam int PRESC_W       = 10;

    typedef logic [PRESC_W-1:0] presc_t;
    typedef logic [POW_W-1:0]   pow_t;

    // D = 2^pow2 * 5^pow5, saturated at DIV_MAX
    function automatic presc_t div_of(input pow_t pow2, input pow_t pow5);
        presc_t p5;
        presc_t d;
        case (pow5)
            2'd0:    p5 = 10'd1;
            2'd1:    p5 = 10'd5;
            2'd2:    p5 = 10'd25;
            default: p5 = 10'd125;
        endcase
        d = p5 << pow2;
        return (32'(d) > DIV_MAX) ? PRESC_W'(DIV_MAX) : d;
    endfunction

endpackage

// File: rtl/pwm_multi_ctrl_if.sv
// Channel-addressed configuration write bus of the PWM block.
interface pwm_multi_ctrl_if
    import pwm_multi_ctrl_pkg::*;
#(
    parameter int CH_W   = 2,
    parameter int DUTY_W = 7
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [POW_W-1:0]  pow2_cfg;
    logic [POW_W-1:0]  pow5_cfg;
    logic [DUTY_W-1:0] duty_cfg;
    logic              cfg_err;

    modport master (output cfg_valid, cfg_ch, pow2_cfg, pow5_cfg, duty_cfg,
                    input  cfg_ready, cfg_err);
    modport slave  (input  cfg_valid, cfg_ch, pow2_cfg, pow5_cfg, duty_cfg,
                    output cfg_ready, cfg_err);
endinterface

// File: rtl/pwm_multi_ctrl_channel.sv
// One PWM channel: double-buffered config, prescaler, step counter, compare, output flops.
// With PWM_STAGGER_EN defined the step counter starts at (K*STEPS)/N_CH instead of 0.
module pwm_channel
    import pwm_multi_ctrl_pkg::*;
#(
    parameter int K      = 0,
    parameter int N_CH   = 4,
    parameter int STEPS  = STEPS_DEFAULT,
    parameter int DUTY_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr,
    input  pow_t              pow2,
    input  pow_t              pow5,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm,
    output logic              pstart
);
`ifdef PWM_STAGGER_EN
    localparam int STAGGER = 1;
`else
    localparam int STAGGER = 0;
`endif
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int START  = (STAGGER != 0) ? (K * STEPS) / N_CH : 0;
    localparam logic [STEP_W-1:0] STEP_START = STEP_W'(START);
    localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEPS - 1);

    pow_t              pow2_a_r, pow5_a_r, pow2_p_r, pow5_p_r;
    logic [DUTY_W-1:0] duty_a_r, duty_p_r;
    logic              pend_r;
    presc_t            presc_r;
    logic [STEP_W-1:0] step_r;
    presc_t            div_s;
    logic              tick_s, bound_s, load_s;

    // Period timing and when the pending copy becomes active
    always_comb begin
        div_s   = div_of(pow2_a_r, pow5_a_r);
        tick_s  = (presc_r == (div_s - PRESC_W'(1)));
        bound_s = en & tick_s & (step_r == STEP_LAST);
        load_s  = pend_r & (~en | bound_s);
    end

    // Prescaler and step counter; held at the start value while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
            step_r  <= STEP_START;
        end else if (!en) begin
            presc_r <= '0;
            step_r  <= STEP_START;
        end else if (tick_s) begin
            presc_r <= '0;
            step_r  <= (step_r == STEP_LAST) ? STEP_W'(0) : step_r + STEP_W'(1);
        end else begin
            presc_r <= presc_r + PRESC_W'(1);
        end
    end

    // Pending/active config; a write on the load cycle lands in pending for the next boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pow2_p_r <= '0;
            pow5_p_r <= '0;
            duty_p_r <= '0;
            pow2_a_r <= '0;
            pow5_a_r <= '0;
            duty_a_r <= '0;
            pend_r   <= 1'b0;
        end else begin
            if (wr) begin
                pow2_p_r <= pow2;
                pow5_p_r <= pow5;
                duty_p_r <= duty;
            end
            if (load_s) begin
                pow2_a_r <= pow2_p_r;
                pow5_a_r <= pow5_p_r;
                duty_a_r <= duty_p_r;
            end
            pend_r <= wr | (pend_r & ~load_s);
        end
    end

    // Output compare, one clock behind the counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm    <= 1'b0;
            pstart <= 1'b0;
        end else begin
            pwm    <= en & (32'(step_r) < 32'(duty_a_r));
            pstart <= en & (step_r == STEP_W'(0)) & (presc_r == PRESC_W'(0));
        end
    end

endmodule

// File: rtl/pwm_multi_ctrl.sv
// N-channel PWM top: config write decode, cfg_ready/cfg_err, one pwm_channel per channel.
// Optional build macro (inside the channels): PWM_STAGGER_EN.
module pwm_multi_ctrl
    import pwm_multi_ctrl_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CH_W   = 2,
    parameter int DUTY_W = 7,
    parameter int STEPS  = STEPS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   ch_en,
    pwm_multi_ctrl_if.slave   cfg,
    output logic [N_CH-1:0]   pwm_out,
    output logic [N_CH-1:0]   period_start
);
    logic              cfg_ready_r, cfg_err_r;
    logic              wr_s, ch_ok_s;
    logic [CH_W-1:0]   ch_s;
    logic [DUTY_W-1:0] duty_s;

    // Write strobe, address range check and duty clamp
    always_comb begin
        ch_s    = cfg.cfg_ch;
        wr_s    = cfg.cfg_valid & cfg_ready_r;
        ch_ok_s = (32'(ch_s) < 32'(N_CH));
        duty_s  = (32'(cfg.duty_cfg) > DUTY_MAX) ? DUTY_W'(DUTY_MAX) : cfg.duty_cfg;
    end

    // Ready after reset release; error pulse for out-of-range channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ready_r <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            cfg_ready_r <= 1'b1;
            cfg_err_r   <= wr_s & ~ch_ok_s;
        end
    end

    assign cfg.cfg_ready = cfg_ready_r;
    assign cfg.cfg_err   = cfg_err_r;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic wr_k_s;
        assign wr_k_s = wr_s & ch_ok_s & (32'(ch_s) == 32'(k));

        pwm_channel #(
            .K      (k),
            .N_CH   (N_CH),
            .STEPS  (STEPS),
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (ch_en[k]),
            .wr     (wr_k_s),
            .pow2   (cfg.pow2_cfg),
            .pow5   (cfg.pow5_cfg),
            .duty   (duty_s),
            .pwm    (pwm_out[k]),
            .pstart (period_start[k])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Scoreboard bench for pwm_multi_ctrl: expected (period length, high clocks) pushed per write,
// popped and compared as each measured DUT period completes.
module tb_pwm_multi_ctrl;
    localparam int N_CH  = 4;
    localparam int LIMIT = 2000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] pwm_out;
    logic [N_CH-1:0] period_start;

    pwm_multi_ctrl_if #(.CH_W(3), .DUTY_W(7)) cfg_bus ();

    pwm_multi_ctrl #(.N_CH(N_CH), .CH_W(3), .DUTY_W(7), .STEPS(100)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .cfg          (cfg_bus),
        .pwm_out      (pwm_out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    total = 0;
    int    bad   = 0;
    int    last_ps = 0;
    string tag_q[$];
    int    len_q[$];
    int    hi_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int len, input int hi);
        tag_q.push_back(tag);
        len_q.push_back(len);
        hi_q.push_back(hi);
    endtask

    task automatic wr(input int ch, input int p2, input int p5, input int duty);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 3'(ch);
        cfg_bus.pow2_cfg  = 2'(p2);
        cfg_bus.pow5_cfg  = 2'(p5);
        cfg_bus.duty_cfg  = 7'(duty);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    // Advance to the next negedge showing period_start[c]
    task automatic sync_ps(input int c, input string tag);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < LIMIT) begin
            @(negedge clk);
            n++;
            if (period_start[c]) found = 1'b1;
        end
        chk({tag, ".sync"}, int'(found), 1);
        last_ps = cyc;
    endtask

    // From a period_start negedge, measure one period and score it
    task automatic measure(input int c);
        int    len = 1;
        int    hi;
        bit    found = 1'b0;
        string t;
        hi = int'(pwm_out[c]);
        while (!found && len < LIMIT) begin
            @(negedge clk);
            if (period_start[c]) found = 1'b1;
            else begin
                len++;
                hi += int'(pwm_out[c]);
            end
        end
        last_ps = cyc;
        chk("sb.avail", int'(tag_q.size() > 0), 1);
        if (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            chk({t, ".found"}, int'(found), 1);
            chk({t, ".len"}, len, len_q.pop_front());
            chk({t, ".hi"}, hi, hi_q.pop_front());
        end
    endtask

    int p0;

    initial begin
        rst_n = 1'b0;
        ch_en = '0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.pow2_cfg  = '0;
        cfg_bus.pow5_cfg  = '0;
        cfg_bus.duty_cfg  = '0;
        repeat (3) @(negedge clk);
        chk("rst.ready", int'(cfg_bus.cfg_ready), 0);
        chk("rst.pwm", int'(pwm_out), 0);
        chk("rst.ps", int'(period_start), 0);
        chk("rst.err", int'(cfg_bus.cfg_err), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready_rel", int'(cfg_bus.cfg_ready), 1);

        // 1: duty 25 at D=1
        ch_en = 4'b0001;
        wr(0, 0, 0, 25);
        push_exp("t1a", 100, 25);
        push_exp("t1b", 100, 25);
        sync_ps(0, "t1");
        measure(0);
        measure(0);

        // 2: mid-period switch to D=4
        p0 = last_ps;
        repeat (30) @(negedge clk);
        wr(0, 2, 0, 25);
        chk("t2.err", int'(cfg_bus.cfg_err), 0);
        sync_ps(0, "t2");
        chk("t2.cur_len", last_ps - p0, 100);
        push_exp("t2a", 400, 100);
        push_exp("t2b", 400, 100);
        measure(0);
        measure(0);

        // 3: duty extremes and clamp
        wr(0, 0, 0, 0);
        push_exp("t3_d0", 100, 0);
        sync_ps(0, "t3a");
        measure(0);
        wr(0, 0, 0, 100);
        push_exp("t3_d100", 100, 100);
        sync_ps(0, "t3b");
        measure(0);
        wr(0, 0, 0, 120);
        push_exp("t3_d120", 100, 100);
        sync_ps(0, "t3c");
        measure(0);

        // 4: last write wins, out-of-range channel
        ch_en = 4'b0011;
        wr(1, 0, 0, 30);
        wr(1, 0, 0, 70);
        push_exp("t4_lww", 100, 70);
        sync_ps(1, "t4a");
        measure(1);
        wr(5, 0, 0, 10);
        chk("t4.err_pulse", int'(cfg_bus.cfg_err), 1);
        @(negedge clk);
        chk("t4.err_clear", int'(cfg_bus.cfg_err), 0);
        push_exp("t4_ch0", 100, 100);
        sync_ps(0, "t4b");
        measure(0);
        push_exp("t4_ch1", 100, 70);
        sync_ps(1, "t4c");
        measure(1);

        // disabled channels take writes at once; enable starts a fresh, aligned period
        wr(2, 0, 0, 50);
        wr(3, 0, 0, 50);
        repeat (2) @(negedge clk);
        chk("en.pwm_off", int'(pwm_out[2]), 0);
        chk("en.ps_off", int'(period_start[2]), 0);
        ch_en = 4'b1111;
        @(negedge clk);
        chk("en.ps2", int'(period_start[2]), 1);
        chk("en.pwm2", int'(pwm_out[2]), 1);
`ifndef PWM_STAGGER_EN
        chk("en.ps3", int'(period_start[3]), 1);
        chk("en.pwm3", int'(pwm_out[3]), 1);
`endif
        push_exp("en_ch2", 100, 50);
        measure(2);

        // 5a: second write lands exactly on the boundary
        sync_ps(0, "t5a");
        wr(0, 0, 0, 40);
        repeat (97) @(negedge clk);
        wr(0, 0, 0, 60);
        push_exp("t5_old", 100, 40);
        push_exp("t5_new", 100, 60);
        sync_ps(0, "t5b");
        measure(0);
        measure(0);

        // 5b: reset mid-period drops outputs at once and discards pending
        wr(0, 0, 0, 80);
        repeat (20) @(negedge clk);
        chk("t5.pwm_before", int'(pwm_out[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.pwm_async", int'(pwm_out), 0);
        chk("t5.ready_async", int'(cfg_bus.cfg_ready), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push_exp("t5_rst1", 100, 0);
        push_exp("t5_rst2", 100, 0);
        sync_ps(0, "t5c");
        measure(0);
        measure(0);

        chk("sb.leftover", tag_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
